// File: rtl/div_ctrl.sv
// div_ctrl: iterative signed/unsigned integer divider controller.
// Accepts one divide at a time, runs one restoring radix-2 step per cycle,
// fixes the result signs, and presents {remainder, quotient} on C with a
// one-cycle done pulse. A zero divisor short-circuits to a flagged result.
module div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sign,
    input  logic [DATA_WIDTH-1:0]     A,
    input  logic [DATA_WIDTH-1:0]     B,
    input  logic                      flush,
    output logic                      busy,
    output logic                      stall,
    output logic                      done,
    output logic                      div_by_zero,
    output logic [2*DATA_WIDTH-1:0]   C
);

    localparam int                    CW   = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]         LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         INC  = CW'(1);
    localparam logic [DATA_WIDTH-1:0] ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    state_q;
    logic [CW-1:0]             cnt_q;
    logic [DATA_WIDTH-1:0]     quo_q;    // dividend bits shift out, quotient bits shift in
    logic [DATA_WIDTH-1:0]     rem_q;    // partial remainder, always < divisor
    logic [DATA_WIDTH-1:0]     dvs_q;    // divisor magnitude
    logic                      qneg_q;
    logic                      rneg_q;
    logic [2*DATA_WIDTH-1:0]   c_q;
    logic                      dbz_q;
    logic                      done_q;
    logic                      busy_q;

    logic [DATA_WIDTH:0]       shift_d;
    logic [DATA_WIDTH:0]       diff_d;
    logic                      ge_d;
    logic [DATA_WIDTH-1:0]     rem_d;
    logic [DATA_WIDTH-1:0]     quo_d;
    logic [DATA_WIDTH-1:0]     abs_a_d;
    logic [DATA_WIDTH-1:0]     abs_b_d;
    logic [DATA_WIDTH-1:0]     fix_q_d;
    logic [DATA_WIDTH-1:0]     fix_r_d;

    function automatic logic [DATA_WIDTH-1:0] twos_neg(input logic [DATA_WIDTH-1:0] v);
        return ~v + ONE;
    endfunction

    // Magnitude of an operand; the most negative value maps onto 2^(W-1),
    // which is exactly right when interpreted as an unsigned magnitude.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                        input logic                  is_signed);
        return (is_signed && v[DATA_WIDTH-1]) ? twos_neg(v) : v;
    endfunction

    // Operand magnitudes and sign-corrected results
    always_comb begin
        abs_a_d = magnitude(A, sign);
        abs_b_d = magnitude(B, sign);
        fix_q_d = qneg_q ? twos_neg(quo_q) : quo_q;
        fix_r_d = rneg_q ? twos_neg(rem_q) : rem_q;
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // If the shifted value has its top bit set it already exceeds the divisor;
    // otherwise both operands are below 2^W and bit W of the difference is the borrow.
    always_comb begin
        shift_d = {rem_q, quo_q[DATA_WIDTH-1]};
        diff_d  = shift_d - {1'b0, dvs_q};
        ge_d    = shift_d[DATA_WIDTH] | ~diff_d[DATA_WIDTH];
        rem_d   = ge_d ? diff_d[DATA_WIDTH-1:0] : shift_d[DATA_WIDTH-1:0];
        quo_d   = {quo_q[DATA_WIDTH-2:0], ge_d};
    end

    // Control FSM with registered outputs; flush overrides everything but reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            c_q     <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (B == '0) begin
                            c_q     <= {A, {DATA_WIDTH{1'b1}}};
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            quo_q   <= abs_a_d;
                            rem_q   <= '0;
                            dvs_q   <= abs_b_d;
                            qneg_q  <= (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]) & sign;
                            rneg_q  <= A[DATA_WIDTH-1] & sign;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + INC;
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    c_q     <= {fix_r_d, fix_q_d};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign C           = c_q;
    assign stall       = (start & (state_q == S_IDLE)) | busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed bench for div_ctrl against an
// arithmetic reference model (64-bit integer divide of the operands).
module tb_div_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sign = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           flush = 1'b0;
    logic           busy;
    logic           stall;
    logic           done;
    logic           div_by_zero;
    logic [2*W-1:0] C;

    int             errs = 0;
    int             chks = 0;
    logic [2*W-1:0] exp_c = '0;
    logic           exp_dbz = 1'b0;

    div_ctrl #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .A(A), .B(B),
        .flush(flush), .busy(busy), .stall(stall), .done(done),
        .div_by_zero(div_by_zero), .C(C)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division in 64 bits (truncating toward zero,
    // remainder takes the dividend's sign), or the zero-divisor convention.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         output logic [2*W-1:0] c, output logic dbz);
        longint sa, sb, q, r;
        if (b == 0) begin
            c   = {a, 32'hFFFF_FFFF};
            dbz = 1'b1;
        end else begin
            sa  = sg ? longint'($signed(a)) : longint'(a);
            sb  = sg ? longint'($signed(b)) : longint'(b);
            q   = sa / sb;
            r   = sa % sb;
            c   = {r[31:0], q[31:0]};
            dbz = 1'b0;
        end
    endtask

    // One complete divide; called with the DUT idle, shortly after a rising edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                         input string tag);
        logic [2*W-1:0] want_c;
        logic           want_dbz;
        int             lat;
        int             want_lat;
        model(a, b, sg, want_c, want_dbz);
        want_lat = (b == 0) ? 1 : W + 2;
        A = a; B = b; sign = sg; start = 1'b1;
        #1;
        chks++;
        if (stall !== 1'b1) begin
            errs++; $display("FAIL %s stall_idle: got %b want 1", tag, stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            chks++;
            if (busy !== 1'b1 || stall !== 1'b1 || C !== exp_c) begin
                errs++;
                $display("FAIL %s calc_hold lat=%0d: busy=%b stall=%b C=%h want busy=1 stall=1 C=%h",
                         tag, lat, busy, stall, C, exp_c);
            end
            @(posedge clk); #1;
            lat++;
        end
        chks++;
        if (lat !== want_lat) begin
            errs++; $display("FAIL %s latency: got %0d want %0d", tag, lat, want_lat);
        end
        chks++;
        if (C !== want_c) begin
            errs++; $display("FAIL %s result: got %h want %h", tag, C, want_c);
        end
        chks++;
        if (div_by_zero !== want_dbz || busy !== 1'b0) begin
            errs++; $display("FAIL %s dbz: got dbz=%b busy=%b want dbz=%b busy=0",
                             tag, div_by_zero, busy, want_dbz);
        end
        exp_c   = want_c;
        exp_dbz = want_dbz;
        @(posedge clk); #1;
        chks++;
        if (done !== 1'b0 || C !== exp_c || div_by_zero !== exp_dbz || stall !== 1'b0) begin
            errs++; $display("FAIL %s after_done: done=%b C=%h dbz=%b stall=%b want 0 %h %b 0",
                             tag, done, C, div_by_zero, stall, exp_c, exp_dbz);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chks++;
        if (busy !== 0 || done !== 0 || div_by_zero !== 0 || C !== '0 || stall !== 0) begin
            errs++; $display("FAIL reset_state: busy=%b done=%b dbz=%b C=%h stall=%b want all 0",
                             busy, done, div_by_zero, C, stall);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(32'd100, 32'd7, 1'b0, "udiv_100_7");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv_m7_2");
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, "udiv_fff9_2");
        do_op(32'd5, 32'd0, 1'b0, "div0_5");
        do_op(32'd9, 32'd3, 1'b0, "udiv_9_3");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_overflow");
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, "sdiv_7_m2");
        do_op(32'h8000_0000, 32'd0, 1'b1, "div0_signed");
        do_op(32'd3, 32'd10, 1'b0, "udiv_small");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         sg;
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if (b == 0 && $urandom_range(0, 1) == 1) b = 32'd1;
            do_op(a, b, sg, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_flush();
        do_op(32'd44, 32'd0, 1'b0, "pre_flush_div0");
        A = 32'd1234567; B = 32'd89; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_dbz = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chks++;
        if (busy !== 0 || done !== 0 || C !== exp_c || div_by_zero !== exp_dbz) begin
            errs++; $display("FAIL flush_calc: busy=%b done=%b C=%h dbz=%b want 0 0 %h %b",
                             busy, done, C, div_by_zero, exp_c, exp_dbz);
        end
        for (int i = 0; i < W + 6; i++) begin
            @(posedge clk); #1;
            chks++;
            if (done !== 0 || busy !== 0 || C !== exp_c) begin
                errs++; $display("FAIL flush_quiet cyc=%0d: done=%b busy=%b C=%h want 0 0 %h",
                                 i, done, busy, C, exp_c);
            end
        end
        A = 32'd50; B = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chks++;
        if (busy !== 0 || done !== 0 || C !== exp_c) begin
            errs++; $display("FAIL flush_beats_start: busy=%b done=%b C=%h want 0 0 %h",
                             busy, done, C, exp_c);
        end
        do_op(32'd50, 32'd5, 1'b0, "post_flush");
    endtask

    task automatic test_start_ignored();
        logic [2*W-1:0] want_c;
        logic           want_dbz;
        int             lat;
        int             dones;
        model(32'd1000, 32'd33, 1'b0, want_c, want_dbz);
        A = 32'd1000; B = 32'd33; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        A = 32'd77; B = 32'd0; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        lat = 6;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chks++;
        if (lat !== W + 2 || C !== want_c || div_by_zero !== 1'b0) begin
            errs++; $display("FAIL busy_start_ignored: lat=%0d C=%h dbz=%b want %0d %h 0",
                             lat, C, div_by_zero, W + 2, want_c);
        end
        exp_c = want_c; exp_dbz = 1'b0;
        dones = 0;
        for (int i = 0; i < W + 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        chks++;
        if (dones !== 0 || busy !== 0) begin
            errs++; $display("FAIL no_queued_op: extra dones=%0d busy=%b want 0 0", dones, busy);
        end
    endtask

    task automatic test_reset_mid();
        A = 32'd999; B = 32'd4; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chks++;
        if (busy !== 0 || done !== 0 || div_by_zero !== 0 || C !== '0 || stall !== 0) begin
            errs++; $display("FAIL async_reset: busy=%b done=%b dbz=%b C=%h stall=%b want all 0",
                             busy, done, div_by_zero, C, stall);
        end
        exp_c = '0; exp_dbz = 1'b0;
        #1;
        rst_n = 1'b1;
        do_op(32'hFFFF_FF00, 32'd16, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_ignored();
        test_reset_mid();
        do_op(32'd123456789, 32'd1000, 1'b1, "back_to_back_a");
        do_op(32'hDEAD_BEEF, 32'd0, 1'b1, "back_to_back_b");
        do_op(32'hDEAD_BEEF, 32'h1234, 1'b1, "back_to_back_c");
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
